// File: rtl/mult32x32_fsm_if.sv
// Control bundle between the 32x32 multiplier sequencer and its datapath.
// Latency: none, wires only.
// Backpressure: none; the datapath always follows the control outputs.
//
// Signals: start (request), busy, a_sel, b_sel, shift_sel[1:0], upd_prod, clr_prod.
// master = sequencer side (drives controls), slave = datapath/requester side.
interface mult32x32_fsm_if;
  logic       start;
  logic       busy;
  logic       a_sel;
  logic       b_sel;
  logic [1:0] shift_sel;
  logic       upd_prod;
  logic       clr_prod;

  modport master (
    input  start,
    output busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod
  );

  modport slave (
    output start,
    input  busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod
  );
endinterface

// File: rtl/mult32x32_fsm.sv
// Sequencer for a 32x32 unsigned multiplier built on one 16x16 multiplier.
// Latency: start sampled at E0, four accumulate cycles, product valid from E4.
// Backpressure: none; start is only accepted in IDLE, ignored otherwise.
//
// Ports: clk (rising edge), reset (async, active low), bus (mult32x32_fsm_if.master):
//   start in; busy, a_sel, b_sel, shift_sel[1:0], upd_prod, clr_prod out.
// Optional: define MULT32X32_FSM_ASSERT_EN to compile in protocol assertions.
module mult32x32_fsm (
  input  logic            clk,
  input  logic            reset,
  mult32x32_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A0B0 = 3'd1,
    A0B1 = 3'd2,
    A1B0 = 3'd3,
    A1B1 = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? A0B0 : IDLE;
      A0B0:    state_d = A0B1;
      A0B1:    state_d = A1B0;
      A1B0:    state_d = A1B1;
      A1B1:    state_d = IDLE;
      // Unused encodings recover to IDLE on the next edge.
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decode the state register only, so they cannot glitch on start.
  always_comb begin
    bus.busy      = 1'b0;
    bus.a_sel     = 1'b0;
    bus.b_sel     = 1'b0;
    bus.shift_sel = 2'd0;
    bus.upd_prod  = 1'b0;
    case (state_q)
      A0B0: begin
        bus.busy     = 1'b1;
        bus.upd_prod = 1'b1;
      end
      A0B1: begin
        bus.busy      = 1'b1;
        bus.b_sel     = 1'b1;
        bus.shift_sel = 2'd1;
        bus.upd_prod  = 1'b1;
      end
      A1B0: begin
        bus.busy      = 1'b1;
        bus.a_sel     = 1'b1;
        bus.shift_sel = 2'd1;
        bus.upd_prod  = 1'b1;
      end
      A1B1: begin
        bus.busy      = 1'b1;
        bus.a_sel     = 1'b1;
        bus.b_sel     = 1'b1;
        bus.shift_sel = 2'd2;
        bus.upd_prod  = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear is Mealy so the product register is zeroed on the same edge that
  // leaves IDLE; gating with reset keeps it low while reset is asserted.
  assign bus.clr_prod = (state_q == IDLE) & bus.start & reset;

`ifdef MULT32X32_FSM_ASSERT_EN
  property p_busy_four;
    @(posedge clk) disable iff (!reset)
      (state_q == IDLE && bus.start) |=> bus.busy [*4] ##1 !bus.busy;
  endproperty
  a_busy_four: assert property (p_busy_four)
    else $error("busy not high for exactly 4 cycles after start");

  a_clr_upd_excl: assert property (@(posedge clk) disable iff (!reset)
    !(bus.clr_prod && bus.upd_prod))
    else $error("clr_prod and upd_prod both high");

  a_shift_legal: assert property (@(posedge clk) disable iff (!reset)
    bus.shift_sel != 2'd3)
    else $error("shift_sel driven to 3");

  a_state_legal: assert property (@(posedge clk) disable iff (!reset)
    state_q inside {IDLE, A0B0, A0B1, A1B0, A1B1})
    else $error("state register holds unused encoding");
`endif

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Directed bench for mult32x32_fsm: reset, single sequence, ignored start,
// back-to-back sequences and asynchronous reset mid-sequence.
module tb_mult32x32_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mult32x32_fsm_if ifc ();

  mult32x32_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Packed as {busy, a_sel, b_sel, shift_sel[1:0], upd_prod, clr_prod}.
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_CLR  = 7'b0000001;
  localparam logic [6:0] O_S0   = 7'b1000010;
  localparam logic [6:0] O_S1   = 7'b1010110;
  localparam logic [6:0] O_S2   = 7'b1100110;
  localparam logic [6:0] O_S3   = 7'b1111010;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {ifc.busy, ifc.a_sel, ifc.b_sel, ifc.shift_sel, ifc.upd_prod, ifc.clr_prod};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] held_seq(input int i);
    case (i % 5)
      0: return O_CLR;
      1: return O_S0;
      2: return O_S1;
      3: return O_S2;
      default: return O_S3;
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with start high: everything stays quiet.
    reset     = 1'b0;
    ifc.start = 1'b1;
    #1;
    chk("reset_async", O_IDLE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", O_IDLE);
    end

    // Release and pulse start for one cycle.
    reset     = 1'b1;
    ifc.start = 1'b1;
    #1;
    chk("seq1_clr", O_CLR);
    step();
    ifc.start = 1'b0;
    chk("seq1_a0b0", O_S0);
    step();
    chk("seq1_a0b1", O_S1);
    step();
    chk("seq1_a1b0", O_S2);
    step();
    chk("seq1_a1b1", O_S3);
    step();
    chk("seq1_idle", O_IDLE);

    // Start pulsed during A0B1 must be ignored.
    ifc.start = 1'b1;
    #1;
    chk("seq2_clr", O_CLR);
    step();
    ifc.start = 1'b0;
    chk("seq2_a0b0", O_S0);
    step();
    ifc.start = 1'b1;
    #1;
    chk("seq2_a0b1_start", O_S1);
    step();
    ifc.start = 1'b0;
    chk("seq2_a1b0", O_S2);
    step();
    chk("seq2_a1b1", O_S3);
    step();
    chk("seq2_idle", O_IDLE);
    step();
    chk("seq2_no_restart", O_IDLE);

    // Start held for 12 cycles: sequences separated by one clearing IDLE cycle.
    ifc.start = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("held_%0d", i), held_seq(i));
      step();
    end
    ifc.start = 1'b0;
    #1;
    chk("held_tail_a0b1", O_S1);
    step();
    chk("held_tail_a1b0", O_S2);
    step();
    chk("held_tail_a1b1", O_S3);
    step();
    chk("held_tail_idle", O_IDLE);

    // Asynchronous reset in the middle of A1B0.
    ifc.start = 1'b1;
    #1;
    chk("rst_mid_clr", O_CLR);
    step();
    ifc.start = 1'b0;
    chk("rst_mid_a0b0", O_S0);
    step();
    step();
    chk("rst_mid_a1b0", O_S2);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_async", O_IDLE);
    ifc.start = 1'b1;
    #0;
    chk("rst_mid_start_low_clr", O_IDLE);
    step();
    chk("rst_mid_held", O_IDLE);
    reset = 1'b1;
    #1;
    chk("restart_clr", O_CLR);
    step();
    ifc.start = 1'b0;
    chk("restart_a0b0", O_S0);
    step();
    chk("restart_a0b1", O_S1);
    step();
    chk("restart_a1b0", O_S2);
    step();
    chk("restart_a1b1", O_S3);
    step();
    chk("restart_idle", O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult32x32_fsm.md
# mult32x32_fsm

Control state machine for the sequential 32x32 unsigned multiplier. The datapath holds a 16x16 multiplier, two 2:1 word selectors, an output shifter and a 64-bit product register. On `start`, this block clears the product register. It then sequences the four 16x16 partial products (A0B0, A0B1, A1B0, A1B1), selecting the operand halves and shift amount and enabling accumulation for each.

## Interface
- Parameters: none.
- `clk` input 1: single system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = in reset); forces IDLE immediately.
- `start` input 1: begin a multiplication; sampled only in IDLE.
- `busy` output 1: high while a multiplication sequence is in progress.
- `a_sel` output 1: operand A half select; 0 = A[15:0], 1 = A[31:16].
- `b_sel` output 1: operand B half select; 0 = B[15:0], 1 = B[31:16].
- `shift_sel` output 2: shifter select; 0 = <<0, 1 = <<16, 2 = <<32; 3 is never driven.
- `upd_prod` output 1: product register accumulates the shifted partial product at the next edge.
- `clr_prod` output 1: product register clears to 0 at the next edge.

## Operation
- States: IDLE, A0B0, A0B1, A1B0, A1B1 (5 states, binary encoded, 3-bit register).
- Transitions:
  - IDLE -> A0B0 when `start`=1; otherwise stay in IDLE.
  - A0B0 -> A0B1 -> A1B0 -> A1B1 -> IDLE unconditionally, one state per cycle.
  - Any unused encoding -> IDLE on the next edge.
- Moore outputs per state, as (`busy`, `a_sel`, `b_sel`, `shift_sel`, `upd_prod`):
  - IDLE: 0, 0, 0, 0, 0.
  - A0B0: 1, 0, 0, 0, 1.
  - A0B1: 1, 0, 1, 1, 1.
  - A1B0: 1, 1, 0, 1, 1.
  - A1B1: 1, 1, 1, 2, 1.
- `clr_prod` is Mealy: `clr_prod` = (state==IDLE) & `start` & `reset`. It is never high together with `upd_prod`.
- `start` outside IDLE is ignored. It does not restart, extend or queue a sequence.
- `start` held high continuously starts a new sequence each time IDLE is reached: 1 idle cycle between sequences.
- No arithmetic in this block. The datapath forms product = sum of (A_half x B_half) << shift over the four states, into a 64-bit register.

## Timing
- Reset (`reset`=0): state = IDLE asynchronously. All outputs 0, including `clr_prod`, regardless of `start`.
- Reset release: first rising edge with `reset`=1 evaluates IDLE normally.
- Latency:
  - `start` sampled high at edge E0, with `clr_prod` high during the cycle before E0.
  - `busy`=1 from E0 through E4.
  - `busy` falls after E4; the product is valid in the register from E4 onward.
- Exactly 4 cycles with `upd_prod`=1 per sequence, contiguous.
- Reset mid-sequence: immediate return to IDLE and all outputs 0. Any partial product is abandoned; the next `start` begins from A0B0 with a clear.
- All Moore outputs are glitch-free decodes of the state register only.

## Configuration
- `MULT32X32_FSM_ASSERT_EN`: when defined, concurrent assertions are compiled in, checking:
  - `busy` high for exactly 4 consecutive cycles after `start` in IDLE;
  - `clr_prod` and `upd_prod` never both high;
  - `shift_sel` != 3;
  - state register never holds an unused encoding outside reset.
- Violations report `$error`. When not defined, no assertion code is present and RTL behaviour is identical.

## Test plan
- Hold `reset`=0 with `start`=1 for 3 cycles -> all outputs 0, `clr_prod`=0, state IDLE throughout.
- Release reset, pulse `start` for 1 cycle -> `clr_prod`=1 in that cycle. Then 4 cycles of (`a_sel`,`b_sel`,`shift_sel`) = (0,0,0), (0,1,1), (1,0,1), (1,1,2) with `busy`=`upd_prod`=1, then `busy`=0.
- Pulse `start` again during the A0B1 state -> sequence unaffected, returns to IDLE after A1B1, no second sequence.
- Hold `start`=1 continuously for 12 cycles -> two complete 4-cycle sequences separated by exactly one IDLE cycle with `clr_prod`=1.
- Assert `reset`=0 asynchronously mid-A1B0 -> `busy`, `upd_prod` and all selects drop to 0 immediately. After release plus `start`, the sequence restarts at A0B0.
- With `MULT32X32_FSM_ASSERT_EN` defined, run all above scenarios -> zero assertion failures.
